// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32 load/store initiator to a word-addressed data RAM
module mem_access_unit #(
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              op_write, op_write_n;
    logic [1:0]        op_size, op_size_n;
    logic              op_unsigned, op_unsigned_n;
    logic [1:0]        op_off, op_off_n;
    logic [31:0]       op_wdata, op_wdata_n;
    logic              req_ready_n, resp_valid_n, resp_err_n, we_n;
    logic [31:0]       resp_rdata_n, data_in_n;
    logic [ADDR_W-1:0] address_n;
    logic              req_bad;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                            input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    // Replace only the addressed lane of the word read back from RAM.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] off);
        logic [31:0] m;
        m = w;
        if (size == 2'b00) begin
            case (off)
                2'd0:    m[7:0]   = wd[7:0];
                2'd1:    m[15:8]  = wd[7:0];
                2'd2:    m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end else if (size == 2'b01) begin
            if (off[1]) m[31:16] = wd[15:0];
            else        m[15:0]  = wd[15:0];
        end else begin
            m = wd;
        end
        merge = m;
    endfunction

    assign req_bad = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                     (req_addr[31:ADDR_W+2] != '0);

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        op_write_n    = op_write;
        op_size_n     = op_size;
        op_unsigned_n = op_unsigned;
        op_off_n      = op_off;
        op_wdata_n    = op_wdata;
        resp_valid_n  = resp_valid;
        resp_err_n    = resp_err;
        resp_rdata_n  = resp_rdata;
        we_n          = mem_write_enable;
        address_n     = mem_address;
        data_in_n     = mem_data_in;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_write_n    = req_write;
                    op_size_n     = req_size;
                    op_unsigned_n = req_unsigned;
                    op_off_n      = req_addr[1:0];
                    op_wdata_n    = req_wdata;
                    if (req_bad) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                        resp_rdata_n = '0;
                    end else begin
                        address_n = req_addr[ADDR_W+1:2];
                        cnt_n     = '0;
                        if (req_write && req_size == 2'b10) begin
                            state_n   = WR;
                            we_n      = 1'b1;
                            data_in_n = req_wdata;
                        end else begin
                            state_n = RD;
                        end
                    end
                end
            end
            RD: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (op_write) begin
                        state_n   = WR;
                        we_n      = 1'b1;
                        data_in_n = merge(mem_data_out, op_wdata, op_size, op_off);
                    end else begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b0;
                        resp_rdata_n = extract(mem_data_out, op_size, op_unsigned, op_off);
                    end
                end
            end
            WR: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_n        = '0;
                    state_n      = RESP;
                    we_n         = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b0;
                    resp_rdata_n = '0;
                end
            end
            default: begin
                if (resp_ready) begin
                    state_n      = IDLE;
                    resp_valid_n = 1'b0;
                    resp_err_n   = 1'b0;
                    resp_rdata_n = '0;
                end
            end
        endcase
        req_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            cnt              <= '0;
            op_write         <= 1'b0;
            op_size          <= 2'b00;
            op_unsigned      <= 1'b0;
            op_off           <= 2'b00;
            op_wdata         <= '0;
            req_ready        <= 1'b0;
            resp_valid       <= 1'b0;
            resp_err         <= 1'b0;
            resp_rdata       <= '0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_data_in      <= '0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            op_write         <= op_write_n;
            op_size          <= op_size_n;
            op_unsigned      <= op_unsigned_n;
            op_off           <= op_off_n;
            op_wdata         <= op_wdata_n;
            req_ready        <= req_ready_n;
            resp_valid       <= resp_valid_n;
            resp_err         <= resp_err_n;
            resp_rdata       <= resp_rdata_n;
            mem_write_enable <= we_n;
            mem_address      <= address_n;
            mem_data_in      <= data_in_n;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_data_in, mem_data_out;
    logic        resp_valid, resp_ready, resp_err, mem_we;
    logic [9:0]  mem_address;

    logic        b_reset_n, b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata, b_mem_data_in, b_mem_data_out;
    logic        b_resp_valid, b_resp_ready, b_resp_err, b_mem_we;
    logic [9:0]  b_mem_address;

    logic [31:0] ram1 [1024];
    logic [31:0] ram3 [1024];

    always @(posedge clk) if (mem_we) ram1[mem_address] <= mem_data_in;
    always @(posedge clk) if (b_mem_we) ram3[b_mem_address] <= b_mem_data_in;
    assign mem_data_out   = ram1[mem_address];
    assign b_mem_data_out = ram3[b_mem_address];

    mem_access_unit #(.ADDR_W(10), .MEM_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_write_enable(mem_we), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    mem_access_unit #(.ADDR_W(10), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(b_reset_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
        .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_write_enable(b_mem_we), .mem_address(b_mem_address), .mem_data_in(b_mem_data_in),
        .mem_data_out(b_mem_data_out)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
    } vec_t;

    vec_t vt[$];

    task automatic run_vec(input vec_t v);
        int n;
        int wes;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1; req_write = v.wr; req_size = v.size;
        req_unsigned = v.uns; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1; wes = 0;
        while (!resp_valid && n < 40) begin
            wes += int'(mem_we);
            @(posedge clk); #1; n++;
        end
        check({v.name, " latency"}, 32'(n), 32'(v.lat));
        check({v.name, " rdata"}, resp_rdata, v.rdata);
        check({v.name, " err"}, 32'(resp_err), 32'(v.err));
        check({v.name, " write cycles"}, 32'(wes), 32'(v.wes));
        if (!v.err) check({v.name, " address"}, 32'(mem_address), 32'(v.addr[11:2]));
        @(posedge clk); #1;
        check({v.name, " resp cleared"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int n;
        logic seen;
        vt.push_back('{"SW 010",  1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1});
        vt.push_back('{"LW 010",  1'b0, 2'b10, 1'b1, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0});
        vt.push_back('{"SW 020",  1'b1, 2'b10, 1'b0, 32'h020, 32'h11223344, 32'h0,        1'b0, 2, 1});
        vt.push_back('{"SB 023",  1'b1, 2'b00, 1'b0, 32'h023, 32'h0000A580, 32'h0,        1'b0, 3, 1});
        vt.push_back('{"LW 020",  1'b0, 2'b10, 1'b0, 32'h020, 32'h0,        32'h80223344, 1'b0, 2, 0});
        vt.push_back('{"LB 023",  1'b0, 2'b00, 1'b0, 32'h023, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0});
        vt.push_back('{"LBU 023", 1'b0, 2'b00, 1'b1, 32'h023, 32'h0,        32'h00000080, 1'b0, 2, 0});
        vt.push_back('{"LH 022",  1'b0, 2'b01, 1'b0, 32'h022, 32'h0,        32'hFFFF8022, 1'b0, 2, 0});
        vt.push_back('{"LHU 020", 1'b0, 2'b01, 1'b1, 32'h020, 32'h0,        32'h00003344, 1'b0, 2, 0});
        vt.push_back('{"LW 006",  1'b0, 2'b10, 1'b0, 32'h006, 32'h0,        32'h0,        1'b1, 1, 0});
        vt.push_back('{"SH 001",  1'b1, 2'b01, 1'b0, 32'h001, 32'h1234,     32'h0,        1'b1, 1, 0});
        vt.push_back('{"SZ 11",   1'b0, 2'b11, 1'b0, 32'h000, 32'h0,        32'h0,        1'b1, 1, 0});
        vt.push_back('{"LW 1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,       32'h0,        1'b1, 1, 0});
        vt.push_back('{"SH 022",  1'b1, 2'b01, 1'b0, 32'h022, 32'hFFFF1234, 32'h0,        1'b0, 3, 1});
        vt.push_back('{"LW 020b", 1'b0, 2'b10, 1'b0, 32'h020, 32'h0,        32'h12343344, 1'b0, 2, 0});
        vt.push_back('{"LB 020",  1'b0, 2'b00, 1'b0, 32'h020, 32'h0,        32'h00000044, 1'b0, 2, 0});
        vt.push_back('{"LBU 021", 1'b0, 2'b00, 1'b1, 32'h021, 32'h0,        32'h00000033, 1'b0, 2, 0});
        vt.push_back('{"SB 020",  1'b1, 2'b00, 1'b0, 32'h020, 32'h000000FF, 32'h0,        1'b0, 3, 1});
        vt.push_back('{"LB 020b", 1'b0, 2'b00, 1'b0, 32'h020, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 0});
        vt.push_back('{"LW 020c", 1'b0, 2'b10, 1'b0, 32'h020, 32'h0,        32'h123433FF, 1'b0, 2, 0});

        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        b_reset_n = 1'b0; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_size = 2'b00;
        b_req_unsigned = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst we", 32'(mem_we), 32'd0);
        check("rst address", 32'(mem_address), 32'd0);
        reset_n = 1'b1; b_reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst release ready", 32'(req_ready), 32'd1);

        // Reset held for two cycles while a load is in RD.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h010;
        @(posedge clk); #1;
        req_valid = 1'b0; reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst req_ready", 32'(req_ready), 32'd0);
        check("midrst resp_valid", 32'(resp_valid), 32'd0);
        check("midrst we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midrst ready before edge", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("midrst ready after edge", 32'(req_ready), 32'd1);
        check("midrst no resp", 32'(resp_valid), 32'd0);

        foreach (vt[i]) run_vec(vt[i]);

        // Response back-pressure with a competing request pending.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h010;
        @(posedge clk); #1;
        req_addr = 32'h020;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            check("hold resp_valid", 32'(resp_valid), 32'd1);
            check("hold rdata", resp_rdata, 32'hDEADBEEF);
            check("hold req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        check("hold still valid", 32'(resp_valid), 32'd1);
        @(posedge clk); #1;
        check("after hs resp_valid", 32'(resp_valid), 32'd0);
        check("after hs ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pending accepted", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("pending resp_valid", 32'(resp_valid), 32'd1);
        check("pending rdata", resp_rdata, 32'h123433FF);
        @(posedge clk); #1;

        // MEM_LATENCY=3: store word, then RMW halfword, then reset mid-WR.
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_size = 2'b10;
        b_req_addr = 32'h040; b_req_wdata = 32'h11223344;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        n = 1;
        while (!b_resp_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("L3 SW latency", 32'(n), 32'd4);
        @(posedge clk); #1;
        b_req_valid = 1'b1; b_req_size = 2'b01; b_req_addr = 32'h042; b_req_wdata = 32'h0000BEEF;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("L3 SH we c%0d", c), 32'(b_mem_we), (c >= 4) ? 32'd1 : 32'd0);
            check($sformatf("L3 SH addr c%0d", c), 32'(b_mem_address), 32'd16);
            check($sformatf("L3 SH resp c%0d", c), 32'(b_resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        check("L3 SH resp cycle 7", 32'(b_resp_valid), 32'd1);
        check("L3 SH ram word", ram3[16], 32'hBEEF3344);
        @(posedge clk); #1;
        b_req_valid = 1'b1; b_req_wdata = 32'h00005555;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("L3 rst 2nd WR we", 32'(b_mem_we), 32'd1);
        b_reset_n = 1'b0;
        @(posedge clk); #1;
        check("L3 rst we low", 32'(b_mem_we), 32'd0);
        check("L3 rst no resp", 32'(b_resp_valid), 32'd0);
        b_reset_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | b_resp_valid | b_mem_we;
        end
        check("L3 rst quiet", 32'(seen), 32'd0);
        check("L3 rst ready", 32'(b_req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
